// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants, Tuse/Tnew encodings and hazard helper
//
// Purpose: shared constants for the pipeline control blocks.
// Ports:   none (package).
package mips_pkg;

   // Primary opcodes (id_ir[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   // SPECIAL funct codes (id_ir[5:0])
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2a;
   localparam logic [5:0] FN_SLTU  = 6'h2b;

   // Tuse / Tnew are cycles-until-needed / cycles-until-produced, 0..2
   typedef logic [1:0] t_time_t;
   localparam t_time_t T_0 = 2'd0;
   localparam t_time_t T_1 = 2'd1;
   localparam t_time_t T_2 = 2'd2;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // A source operand must wait if a younger-than-ready producer in EX or
   // MEM writes it. $0 is hardwired, so it never hazards.
   function automatic logic src_hazard(
      input logic       used,
      input logic [4:0] src,
      input t_time_t    tuse,
      input logic [4:0] e_dst,
      input t_time_t    e_tnew,
      input logic [4:0] m_dst,
      input t_time_t    m_tnew
   );
      return used && (src != 5'd0) &&
             (((e_dst == src) && (e_tnew > tuse)) ||
              ((m_dst == src) && (m_tnew > tuse)));
   endfunction

endpackage

// File: rtl/instr_class.sv
// rtl/instr_class.sv - combinational Tuse/Tnew/destination decode of the ID instruction
//
// Purpose: classify id_ir for the hazard controller.
// Ports:   id_ir     - instruction in ID
//          rs_use/rt_use, tuse_rs/tuse_rt - which sources are read and when
//          dst/tnew  - written register (0 = none) and cycles until result is ready
//          is_md     - touches HI/LO or the mult/div unit
//          md_start  - launches a mult/div; md_is_div selects the long latency
module instr_class
   import mips_pkg::*;
(
   input  logic [31:0] id_ir,
   output logic        rs_use,
   output logic        rt_use,
   output t_time_t     tuse_rs,
   output t_time_t     tuse_rt,
   output logic [4:0]  dst,
   output t_time_t     tnew,
   output logic        is_md,
   output logic        md_start,
   output logic        md_is_div
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       unused_shamt;

   assign opcode       = id_ir[31:26];
   assign rt           = id_ir[20:16];
   assign rd           = id_ir[15:11];
   assign funct        = id_ir[5:0];
   assign unused_shamt = ^id_ir[10:6];

   always_comb begin
      rs_use    = 1'b0;
      rt_use    = 1'b0;
      tuse_rs   = T_0;
      tuse_rt   = T_0;
      dst       = 5'd0;
      tnew      = T_0;
      is_md     = 1'b0;
      md_start  = 1'b0;
      md_is_div = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               // Immediate shifts read rt only
               FN_SLL, FN_SRL, FN_SRA: begin
                  rt_use = 1'b1; tuse_rt = T_1;
                  dst = rd; tnew = T_1;
               end
               FN_SLLV, FN_SRLV, FN_SRAV,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                  rs_use = 1'b1; tuse_rs = T_1;
                  rt_use = 1'b1; tuse_rt = T_1;
                  dst = rd; tnew = T_1;
               end
               FN_JR: begin
                  rs_use = 1'b1; tuse_rs = T_0;
               end
               FN_JALR: begin
                  rs_use = 1'b1; tuse_rs = T_0;
                  dst = rd; tnew = T_0;
               end
               FN_MFHI, FN_MFLO: begin
                  is_md = 1'b1;
                  dst = rd; tnew = T_1;
               end
               FN_MTHI, FN_MTLO: begin
                  is_md = 1'b1;
                  rs_use = 1'b1; tuse_rs = T_1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  is_md = 1'b1; md_start = 1'b1;
                  md_is_div = (funct == FN_DIV) || (funct == FN_DIVU);
                  rs_use = 1'b1; tuse_rs = T_1;
                  rt_use = 1'b1; tuse_rt = T_1;
               end
               default: ;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            rs_use = 1'b1; tuse_rs = T_0;
            rt_use = 1'b1; tuse_rt = T_0;
         end
         OP_ADDIU, OP_ORI: begin
            rs_use = 1'b1; tuse_rs = T_1;
            dst = rt; tnew = T_1;
         end
         OP_LUI: begin
            dst = rt; tnew = T_1;
         end
         OP_LW: begin
            rs_use = 1'b1; tuse_rs = T_1;
            dst = rt; tnew = T_2;
         end
         // Store data is only needed in MEM, so rt may come from a load in MEM
         OP_SW: begin
            rs_use = 1'b1; tuse_rs = T_1;
            rt_use = 1'b1; tuse_rt = T_2;
         end
         OP_JAL: begin
            dst = 5'd31; tnew = T_0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/bubble controller for the 5-stage MIPS pipeline
//
// Purpose: tracks EX/MEM destination and Tnew plus a mult/div busy countdown,
//          and holds ID whenever its operands or HI/LO are not yet available.
// Ports:   clk, reset (sync, active-high)
//          id_ir        - instruction in ID
//          stall        - hold PC and IF/ID this cycle
//          pc_en/ifid_en- freeze enables (~stall)
//          idex_nop     - load a bubble into ID/EX (== stall)
//          md_busy      - mult/div unit occupied
//          stall_cycles - free-running count of stalled cycles
module hazard_stall_ctrl
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] id_ir,
   output logic        stall,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_nop,
   output logic        md_busy,
   output logic [31:0] stall_cycles
);

   localparam logic [15:0] MULT_LD = 16'(MULT_CYCLES);
   localparam logic [15:0] DIV_LD  = 16'(DIV_CYCLES);

   logic       rs_use, rt_use, is_md, md_start, md_is_div;
   t_time_t    tuse_rs, tuse_rt, tnew;
   logic [4:0] dst;

   logic [4:0]  e_dst_q, e_dst_d, m_dst_q, m_dst_d;
   t_time_t     e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
   logic        e_md_start_q, e_md_start_d, e_md_div_q, e_md_div_d;
   logic [15:0] md_cnt_q, md_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        rs_hazard, rt_hazard, md_hazard;

   instr_class u_class (
      .id_ir     (id_ir),
      .rs_use    (rs_use),
      .rt_use    (rt_use),
      .tuse_rs   (tuse_rs),
      .tuse_rt   (tuse_rt),
      .dst       (dst),
      .tnew      (tnew),
      .is_md     (is_md),
      .md_start  (md_start),
      .md_is_div (md_is_div)
   );

   assign rs_hazard = src_hazard(rs_use, id_ir[25:21], tuse_rs,
                                 e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
   assign rt_hazard = src_hazard(rt_use, id_ir[20:16], tuse_rt,
                                 e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
   // A mult/div sitting in EX has not loaded the counter yet, so count it as busy
   assign md_busy   = (md_cnt_q != 16'd0) | e_md_start_q;
   assign md_hazard = is_md & md_busy;

   assign stall        = rs_hazard | rt_hazard | md_hazard;
   assign pc_en        = ~stall;
   assign ifid_en      = ~stall;
   assign idex_nop     = stall;
   assign stall_cycles = stall_cnt_q;

   always_comb begin
      // Bubble into EX when stalling: it writes nothing and starts nothing
      e_dst_d      = stall ? 5'd0 : dst;
      e_tnew_d     = stall ? T_0  : tnew;
      e_md_start_d = stall ? 1'b0 : md_start;
      e_md_div_d   = stall ? 1'b0 : md_is_div;

      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q != T_0) ? e_tnew_q - T_1 : T_0;

      if (e_md_start_q) begin
         md_cnt_d = e_md_div_q ? DIV_LD : MULT_LD;
      end else if (md_cnt_q != 16'd0) begin
         md_cnt_d = md_cnt_q - 16'd1;
      end else begin
         md_cnt_d = md_cnt_q;
      end

      stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst_q      <= 5'd0;
         e_tnew_q     <= T_0;
         e_md_start_q <= 1'b0;
         e_md_div_q   <= 1'b0;
         m_dst_q      <= 5'd0;
         m_tnew_q     <= T_0;
         md_cnt_q     <= 16'd0;
         stall_cnt_q  <= 32'd0;
      end else begin
         e_dst_q      <= e_dst_d;
         e_tnew_q     <= e_tnew_d;
         e_md_start_q <= e_md_start_d;
         e_md_div_q   <= e_md_div_d;
         m_dst_q      <= m_dst_d;
         m_tnew_q     <= m_tnew_d;
         md_cnt_q     <= md_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] id_ir;
   logic        stall, pc_en, ifid_en, idex_nop, md_busy;
   logic [31:0] stall_cycles;

   int vectors = 0;
   int errors  = 0;

   hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_ir        (id_ir),
      .stall        (stall),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_nop     (idex_nop),
      .md_busy      (md_busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Hand-encoded instructions
   logic [31:0] LW8, LW4, LW0, ADDU_9_8_8, BEQ_8_0, ORI_8, SW8, JR8;
   logic [31:0] ADDU_0_1_1, ADDU_2_0_0, MULT12, MFLO3, DIV12, MFHI3;
   logic [31:0] ADDU_3_1_2, ADDU_5_4_3;

   // Present ir in ID and count the cycles it is held. Returns md_busy
   // observed on the cycle it advances. Bounded so a stuck stall cannot hang.
   task automatic issue(input logic [31:0] ir, output int n, output logic busy_go);
      id_ir = ir;
      #1;
      n = 0;
      while (stall === 1'b1 && n < 64) begin
         n++;
         @(posedge clk); #1;
      end
      busy_go = md_busy;
      @(posedge clk); #1;
      id_ir = 32'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      id_ir = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      vectors++; if (pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en got=%b exp=1", pc_en); end
      vectors++; if (ifid_en !== 1'b1) begin errors++; $display("FAIL reset_ifid_en got=%b exp=1", ifid_en); end
      vectors++; if (idex_nop !== 1'b0) begin errors++; $display("FAIL reset_idex_nop got=%b exp=0", idex_nop); end
      vectors++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
      vectors++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
   endtask

   task automatic test_load_use();
      int n; logic b;
      do_reset();
      issue(LW8, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL lu_lw_stalls got=%0d exp=0", n); end
      id_ir = ADDU_9_8_8; #1;
      vectors++; if ({stall, idex_nop, pc_en, ifid_en} !== 4'b1100) begin
         errors++; $display("FAIL lu_outputs got=%b exp=1100", {stall, idex_nop, pc_en, ifid_en}); end
      issue(ADDU_9_8_8, n, b);
      vectors++; if (n !== 1) begin errors++; $display("FAIL lu_addu_stalls got=%0d exp=1", n); end
      vectors++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
   endtask

   task automatic test_branch();
      int n; logic b;
      do_reset();
      issue(LW8, n, b);
      issue(BEQ_8_0, n, b);
      vectors++; if (n !== 2) begin errors++; $display("FAIL br_after_lw got=%0d exp=2", n); end
      issue(ORI_8, n, b);
      issue(BEQ_8_0, n, b);
      vectors++; if (n !== 1) begin errors++; $display("FAIL br_after_alu got=%0d exp=1", n); end
      issue(ORI_8, n, b);
      issue(JR8, n, b);
      vectors++; if (n !== 1) begin errors++; $display("FAIL jr_after_alu got=%0d exp=1", n); end
      vectors++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL br_count got=%0d exp=4", stall_cycles); end
   endtask

   task automatic test_no_false_stall();
      int n; logic b; int seen;
      do_reset();
      issue(LW8, n, b);
      issue(SW8, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL sw_after_lw got=%0d exp=0", n); end
      issue(ADDU_0_1_1, n, b);
      issue(ADDU_2_0_0, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL r0_after_alu got=%0d exp=0", n); end
      issue(LW0, n, b);
      issue(ADDU_2_0_0, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL r0_after_lw got=%0d exp=0", n); end
      seen = 0;
      id_ir = 32'd0;
      for (int i = 0; i < 8; i++) begin
         #1; if (stall !== 1'b0) seen++;
         @(posedge clk); #1;
      end
      vectors++; if (seen !== 0) begin errors++; $display("FAIL bubble_stream got=%0d exp=0", seen); end
      vectors++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL nfs_count got=%0d exp=0", stall_cycles); end
   endtask

   task automatic test_mult_div();
      int n; logic b;
      do_reset();
      issue(MULT12, n, b);
      id_ir = MFLO3; #1;
      vectors++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy got=%b exp=1", md_busy); end
      issue(MFLO3, n, b);
      vectors++; if (n !== 6) begin errors++; $display("FAIL mflo_stalls got=%0d exp=6", n); end
      vectors++; if (b !== 1'b0) begin errors++; $display("FAIL mflo_busy_go got=%b exp=0", b); end
      issue(DIV12, n, b);
      issue(MFHI3, n, b);
      vectors++; if (n !== 11) begin errors++; $display("FAIL mfhi_stalls got=%0d exp=11", n); end
      vectors++; if (b !== 1'b0) begin errors++; $display("FAIL mfhi_busy_go got=%b exp=0", b); end
      vectors++; if (stall_cycles !== 32'd17) begin errors++; $display("FAIL md_count got=%0d exp=17", stall_cycles); end
   endtask

   task automatic test_reset_during_div();
      int n; logic b;
      do_reset();
      issue(DIV12, n, b);
      id_ir = MFHI3;
      repeat (3) begin @(posedge clk); #1; end
      vectors++; if (md_busy !== 1'b1 || stall !== 1'b1) begin
         errors++; $display("FAIL div_pre_busy got=%b%b exp=11", md_busy, stall); end
      vectors++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL div_pre_count got=%0d exp=3", stall_cycles); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++; if ({md_busy, stall} !== 2'b00) begin
         errors++; $display("FAIL div_abort got=%b%b exp=00", md_busy, stall); end
      vectors++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL div_abort_count got=%0d exp=0", stall_cycles); end
      issue(MFHI3, n, b);
      issue(MFLO3, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL mflo_after_abort got=%0d exp=0", n); end
   endtask

   task automatic test_double_hazard();
      int n; logic b;
      do_reset();
      issue(ADDU_3_1_2, n, b);
      issue(LW4, n, b);
      issue(ADDU_5_4_3, n, b);
      vectors++; if (n !== 1) begin errors++; $display("FAIL dbl_stalls got=%0d exp=1", n); end
      vectors++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL dbl_count got=%0d exp=1", stall_cycles); end
   endtask

   task automatic test_back_to_back();
      int n; logic b;
      do_reset();
      issue(MULT12, n, b);
      issue(MULT12, n, b);
      vectors++; if (n !== 6) begin errors++; $display("FAIL mult_mult got=%0d exp=6", n); end
      issue(LW8, n, b);
      issue(SW8, n, b);
      issue(ADDU_9_8_8, n, b);
      vectors++; if (n !== 0) begin errors++; $display("FAIL late_use got=%0d exp=0", n); end
   endtask

   initial begin
      LW8        = itype(6'h23, 0, 8, 0);
      LW4        = itype(6'h23, 0, 4, 0);
      LW0        = itype(6'h23, 1, 0, 0);
      ADDU_9_8_8 = rtype(8, 8, 9, 6'h21);
      BEQ_8_0    = itype(6'h04, 8, 0, 0);
      ORI_8      = itype(6'h0d, 0, 8, 1);
      SW8        = itype(6'h2b, 0, 8, 4);
      JR8        = rtype(8, 0, 0, 6'h08);
      ADDU_0_1_1 = rtype(1, 1, 0, 6'h21);
      ADDU_2_0_0 = rtype(0, 0, 2, 6'h21);
      MULT12     = rtype(1, 2, 0, 6'h18);
      MFLO3      = rtype(0, 0, 3, 6'h12);
      DIV12      = rtype(1, 2, 0, 6'h1a);
      MFHI3      = rtype(0, 0, 3, 6'h10);
      ADDU_3_1_2 = rtype(1, 2, 3, 6'h21);
      ADDU_5_4_3 = rtype(4, 3, 5, 6'h21);

      reset = 1'b1;
      id_ir = 32'd0;
      test_reset();
      test_load_use();
      test_branch();
      test_no_false_stall();
      test_mult_div();
      test_reset_during_div();
      test_double_hazard();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and bubble controller for the 5-stage MIPS pipeline. It produces the `idex_nop` bubble request consumed by the ID/EX pipeline register, and the freeze enables for the PC and IF/ID. It keeps a shadow pipeline of destination register and Tnew for the EX and MEM stages, plus a multiply/divide busy countdown. Each cycle it compares the instruction in ID against that state to decide whether ID must hold.

## Interface
Parameters:
- MULT_CYCLES, 5, EX-stage busy cycles for mult/multu
- DIV_CYCLES, 10, EX-stage busy cycles for div/divu

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- id_ir  input  32  instruction currently in ID (from IF/ID)
- stall  output  1  1 = hold PC and IF/ID this cycle
- pc_en  output  1  ~stall
- ifid_en  output  1  ~stall
- idex_nop  output  1  1 = ID/EX loads all-zero (bubble); equals stall
- md_busy  output  1  mult/div unit occupied
- stall_cycles  output  32  count of cycles with stall=1, wraps at 2^32

## Operation
Decode of `id_ir` (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]):
- **Tuse_rs:**
  - 0 for beq, bne, jr, jalr.
  - 1 for R-type ALU, addiu, ori, lw, sw, mult/div, mthi/mtlo.
  - Unused otherwise (lui, j, jal, sll shifts).
- **Tuse_rt:**
  - 0 for beq, bne.
  - 1 for R-type ALU, shifts, mult/div.
  - 2 for sw.
  - Unused otherwise.
- **dst:**
  - rd for R-type ALU, shifts, mfhi/mflo, jalr.
  - rt for addiu, ori, lui, lw.
  - 31 for jal.
  - 0 (none) otherwise.
- **Tnew:**
  - 2 for lw.
  - 1 for ALU, shift, lui, mfhi/mflo.
  - 0 for jal/jalr.
- **is_md:** mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- **md_start:** mult, multu, div, divu only.

Hazard rules (register 0 never hazards):
- rs_hazard = rs used, rs≠0, and either:
  - e_dst==rs and e_tnew>Tuse_rs, or
  - m_dst==rs and m_tnew>Tuse_rs.
- rt_hazard: the same comparison using rt and Tuse_rt.
- md_hazard = is_md and (md_busy or e_md_start).
- stall = rs_hazard | rt_hazard | md_hazard.

State update on each posedge (reset has priority):
- **E shadow:**
  - if stall: e_dst←0, e_tnew←0, e_md_start←0;
  - else: e_dst←dst, e_tnew←Tnew, e_md_start←md_start, with e_md_lat recording which latency applies.
- **M shadow:** m_dst←e_dst; m_tnew←e_tnew−1, saturating at 0.
- **md counter:**
  - if e_md_start: md_cnt←MULT_CYCLES or DIV_CYCLES;
  - else if md_cnt≠0: md_cnt−1.
  - md_busy = (md_cnt≠0) | e_md_start.
- **stall_cycles** increments when stall=1.

Reset clears e_*, m_*, md_cnt and stall_cycles to 0, giving stall=0, pc_en=1, ifid_en=1, idex_nop=0, md_busy=0. A reset that arrives while md_cnt is counting aborts the countdown immediately.

## Timing
- stall, pc_en, ifid_en, idex_nop and md_busy are combinational from registered state and id_ir, with zero latency. They are valid in the same cycle the instruction sits in ID.
- A stalled instruction re-evaluates every cycle, and stall drops in the first cycle the hazard clears.
- lw followed by a dependent ALU op: exactly 1 stall cycle.
- lw followed by a dependent beq: 2 stall cycles.
- ALU op followed by a dependent beq or jr: 1 stall cycle.
- sw data (Tuse 2) after lw: 0 stall cycles.
- mult followed by mflo: stall for the cycle mult sits in EX, then MULT_CYCLES more cycles; mflo proceeds when md_cnt reaches 0.
- Simultaneous rs and rt hazards are a single stall. There is no double counting in stall_cycles.
- The all-zero bubble (sll $0) decodes as dst=0, so bubbles never create hazards.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct constants;
  - Tuse/Tnew 2-bit encodings;
  - MULT_CYCLES and DIV_CYCLES defaults.
- Sub-module `instr_class` (combinational decode): id_ir → rs_use, rt_use, tuse_rs, tuse_rt, dst, tnew, is_md, md_start, md_is_div.
- The top level holds the shadow registers, the md counter, the hazard compare and the stall counter.

## Test plan
- **Load-use:** lw $8,0($0) then addu $9,$8,$8 → stall=1 and idex_nop=1 for exactly 1 cycle; stall_cycles=1.
- **Branch after load:** lw $8 then beq $8,$0 → 2 stall cycles. Branch after ALU: ori $8,$0,1 then beq $8,$0 → 1 stall cycle.
- **No false stalls:**
  - lw $8 then sw $8,4($0) → 0 stalls;
  - dependent instructions on $0 → 0 stalls;
  - a stream of id_ir=0 → stall never asserts.
- **Mult then mflo:** mult $1,$2 then mflo $3 → stall for 6 cycles. div $1,$2 then mfhi → stall for 11 cycles; md_busy deasserts on the cycle mfhi advances.
- **Reset during div:** reset asserted 3 cycles into a div countdown → the next cycle md_busy=0, stall=0, stall_cycles=0, and a following mflo proceeds with no stall.
- **Double hazard:** addu $3,$1,$2 then lw $4 then addu $5,$4,$3 → exactly 1 stall (the lw); the $3 hazard is resolved by forwarding (m_tnew=0).
